dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between two requesters: requester 0 (load/store unit) and requester 1 (debug/DMA port).
- Memory model: asynchronous read, synchronous write on posedge clk when We is high.
- Arbitrates between requesters with round-robin priority and a valid/ready request handshake, followed by a one-cycle response pulse.
- Sub-word stores are handled by read-modify-write using a byte strobe.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/byte_merge.sv | 14 +
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_pkg;
    localparam int ADDR_W = 5;

    localparam logic REQ_LSU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: each strobed byte takes the new data, others keep the old word.
module byte_merge #(
    parameter  int BITS = 64,
    localparam int SW   = BITS / 8
) (
    input  logic [BITS-1:0] old_data,
    input  logic [BITS-1:0] new_data,
    input  logic [SW-1:0]   strb,
    output logic [BITS-1:0] merged
);
    for (genvar i = 0; i < SW; i++) begin : g_byte
        assign merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the LSU and the debug/DMA port.
// Sub-word stores are done as read-modify-write through a captured copy of the old word.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter  int BITS  = 64,
    parameter  int DEPTH = 32,
    localparam int SW    = BITS / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r1_valid,
    output logic              r0_ready,
    output logic              r1_ready,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [BITS-1:0]   r0_wdata,
    input  logic [BITS-1:0]   r1_wdata,
    input  logic [SW-1:0]     r0_strb,
    input  logic [SW-1:0]     r1_strb,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [BITS-1:0]   r0_rdata,
    output logic [BITS-1:0]   r1_rdata,
    output logic [ADDR_W-1:0] mem_endr,
    output logic              mem_We,
    output logic [BITS-1:0]   mem_din,
    input  logic [BITS-1:0]   mem_dout
);
    state_t              state, state_nxt;
    logic                last_grant;
    logic                grant_id;
    logic                accept;
    logic                lat_id;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [BITS-1:0]     lat_wdata;
    logic [SW-1:0]       lat_strb;
    logic [BITS-1:0]     resp_data;
    logic [BITS-1:0]     merge_old;
    logic [BITS-1:0]     merged;
    logic                in_range;

    // On a tie the requester that did not win last time is favoured.
    assign grant_id = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    assign in_range = (int'(lat_addr) < DEPTH);

    byte_merge #(.BITS(BITS)) u_merge (
        .old_data (merge_old),
        .new_data (lat_wdata),
        .strb     (lat_strb),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_DBG;
            lat_id     <= REQ_LSU;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_strb   <= '0;
            resp_data  <= '0;
            merge_old  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_id    <= grant_id;
                lat_we    <= grant_id ? r1_we    : r0_we;
                lat_addr  <= grant_id ? r1_addr  : r0_addr;
                lat_wdata <= grant_id ? r1_wdata : r0_wdata;
                lat_strb  <= grant_id ? r1_strb  : r0_strb;
            end
            if (state == ACCESS) begin
                resp_data <= in_range ? mem_dout : '0;
                merge_old <= mem_dout;
            end
            if (state == RESP)
                last_grant <= lat_id;
        end
    end

    // Outputs are forced quiet while rst is high so a write pending in the reset cycle never lands.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        r0_rdata  = '0;
        r1_rdata  = '0;
        mem_endr  = '0;
        mem_We    = 1'b0;
        mem_din   = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (r0_valid || r1_valid) begin
                        accept    = 1'b1;
                        state_nxt = ACCESS;
                        if (grant_id == REQ_DBG) r1_ready = 1'b1;
                        else                     r0_ready = 1'b1;
                    end
                end
                ACCESS: begin
                    mem_endr  = lat_addr;
                    state_nxt = RESP;
                    if (lat_we && in_range) begin
                        if (&lat_strb) begin
                            mem_We  = 1'b1;
                            mem_din = lat_wdata;
                        end else if (|lat_strb) begin
                            state_nxt = MERGE;
                        end
                    end
                end
                MERGE: begin
                    mem_endr  = lat_addr;
                    mem_We    = 1'b1;
                    mem_din   = merged;
                    state_nxt = RESP;
                end
                RESP: begin
                    state_nxt = IDLE;
                    if (lat_id == REQ_LSU) begin
                        r0_rvalid = 1'b1;
                        r0_rdata  = lat_we ? '0 : resp_data;
                    end else begin
                        r1_rvalid = 1'b1;
                        r1_rdata  = lat_we ? '0 : resp_data;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a memory/latency model.
module tb_dmem_arbiter;
    localparam int BITS  = 64;
    localparam int DEPTH = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 0, r1_valid = 0, r0_we = 0, r1_we = 0;
    logic [4:0]  r0_addr = 0, r1_addr = 0;
    logic [63:0] r0_wdata = 0, r1_wdata = 0;
    logic [7:0]  r0_strb = 0, r1_strb = 0;
    logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_We;
    logic [63:0] r0_rdata, r1_rdata, mem_din, mem_dout;
    logic [4:0]  mem_endr;

    logic        pl_en = 0;
    logic [4:0]  pl_addr = 0;
    logic [63:0] pl_data = 0;
    logic [63:0] mem [32];
    logic [63:0] model [32];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {int id; int cyc; logic [4:0] addr; logic [63:0] data;} ev_t;
    ev_t resp_q[$];
    ev_t wr_q[$];
    int  both_rdy = 0;
    int  both_rv = 0;

    dmem_arbiter #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_strb(r0_strb), .r1_strb(r1_strb),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_endr(mem_endr), .mem_We(mem_We),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_dout = mem[mem_endr];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_We) mem[mem_endr] <= mem_din;
    end

    always @(negedge clk) begin
        if (r0_rvalid) resp_q.push_back('{id: 0, cyc: cyc, addr: 5'd0, data: r0_rdata});
        if (r1_rvalid) resp_q.push_back('{id: 1, cyc: cyc, addr: 5'd0, data: r1_rdata});
        if (mem_We)    wr_q.push_back('{id: 0, cyc: cyc, addr: mem_endr, data: mem_din});
        if (r0_ready && r1_ready)   both_rdy++;
        if (r0_rvalid && r1_rvalid) both_rv++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] exp_merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic preload(input logic [4:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        pl_en = 1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 0;
        model[a] = d;
    endtask

    task automatic set_req(input int id, input logic v, input logic we, input logic [4:0] a,
                           input logic [63:0] d, input logic [7:0] s);
        if (id == 0) begin r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d; r0_strb = s; end
        else         begin r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d; r1_strb = s; end
    endtask

    // Presents one request and returns the acceptance cycle (-1 if never accepted).
    task automatic drive(input int id, input logic we, input logic [4:0] a, input logic [63:0] d,
                         input logic [7:0] s, output int t);
        t = -1;
        @(posedge clk); #1;
        set_req(id, 1'b1, we, a, d, s);
        for (int n = 0; n < 20 && t < 0; n++) begin
            @(negedge clk);
            if ((id == 0) ? r0_ready : r1_ready) t = cyc;
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0);
    endtask

    task automatic wait_resp(input int from, output int idx);
        idx = -1;
        for (int n = 0; n < 12 && resp_q.size() <= from; n++) begin
            @(negedge clk); #1;
        end
        if (resp_q.size() > from) idx = from;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        r0_valid = 1; r1_valid = 1;
        @(negedge clk);
        n_vec++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_We, mem_endr} !== 10'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 0", {r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_We, mem_endr});
        end
        n_vec++;
        if ({mem_din, r0_rdata, r1_rdata} !== 192'd0) begin
            n_bad++; $display("FAIL reset_data: din=%h rd0=%h rd1=%h required 0", mem_din, r0_rdata, r1_rdata);
        end
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 0; rst = 0;
        @(negedge clk);
        n_vec++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_We, mem_endr, mem_din} !== 74'd0) begin
            n_bad++; $display("FAIL idle_after_reset: outputs not quiet");
        end
    endtask

    task automatic test_round_robin;
        int ids[4], ts[4], k, base, idx;
        logic [4:0] a0, a1;
        a0 = 5'($urandom_range(0, DEPTH-1));
        a1 = 5'($urandom_range(0, DEPTH-1));
        base = resp_q.size();
        k = 0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, a0, 64'd0, 8'd0);
        set_req(1, 1'b1, 1'b0, a1, 64'd0, 8'd0);
        for (int n = 0; n < 40 && k < 4; n++) begin
            @(negedge clk);
            if (r0_ready)      begin ids[k] = 0; ts[k] = cyc; k++; end
            else if (r1_ready) begin ids[k] = 1; ts[k] = cyc; k++; end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0);
        n_vec++;
        if (k !== 4) begin n_bad++; $display("FAIL rr_count: got %0d grants required 4", k); end
        for (int i = 0; i < k; i++) begin
            n_vec++;
            if (ids[i] !== (i % 2)) begin n_bad++; $display("FAIL rr_order[%0d]: got r%0d required r%0d", i, ids[i], i % 2); end
            if (i > 0) begin
                n_vec++;
                if (ts[i] - ts[i-1] !== 3) begin n_bad++; $display("FAIL rr_spacing[%0d]: got %0d required 3", i, ts[i] - ts[i-1]); end
            end
        end
        wait_resp(base + 3, idx);
        n_vec++;
        if (idx < 0) begin n_bad++; $display("FAIL rr_resp: got %0d responses required 4", resp_q.size() - base); end
        else for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (resp_q[base+i].data !== model[(i % 2) ? a1 : a0] || resp_q[base+i].id !== (i % 2)) begin
                n_bad++; $display("FAIL rr_data[%0d]: got r%0d %h required r%0d %h", i, resp_q[base+i].id,
                                  resp_q[base+i].data, i % 2, model[(i % 2) ? a1 : a0]);
            end
        end
    endtask

    task automatic test_load;
        int t, idx, base, r1_cnt;
        preload(5'd2, 64'd94);
        base = resp_q.size();
        drive(0, 1'b0, 5'd2, 64'($urandom), 8'($urandom), t);
        wait_resp(base, idx);
        repeat (3) @(negedge clk);
        n_vec++;
        if (idx < 0) begin n_bad++; $display("FAIL load_resp: no rvalid, required one"); end
        else begin
            n_vec++;
            if (resp_q[idx].id !== 0 || resp_q[idx].cyc !== t + 2) begin
                n_bad++; $display("FAIL load_timing: got r%0d at +%0d required r0 at +2", resp_q[idx].id, resp_q[idx].cyc - t);
            end
            n_vec++;
            if (resp_q[idx].data !== 64'd94) begin n_bad++; $display("FAIL load_data: got %h required %h", resp_q[idx].data, 64'd94); end
        end
        r1_cnt = 0;
        for (int i = base; i < resp_q.size(); i++) if (resp_q[i].id == 1) r1_cnt++;
        n_vec++;
        if (r1_cnt !== 0) begin n_bad++; $display("FAIL load_r1_quiet: got %0d r1 pulses required 0", r1_cnt); end
    endtask

    task automatic test_full_store;
        int t, idx, rb, wb;
        logic [63:0] v;
        v = 64'h1122334455667788;
        rb = resp_q.size(); wb = wr_q.size();
        drive(1, 1'b1, 5'd7, v, 8'hFF, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || resp_q[rb].cyc !== t + 2 || resp_q[rb].id !== 1 || resp_q[rb].data !== 64'd0) begin
            n_bad++; $display("FAIL full_store_resp: idx=%0d, required r1 pulse at +2 with rdata 0", idx);
        end
        n_vec++;
        if (wr_q.size() - wb !== 1) begin n_bad++; $display("FAIL full_store_we_count: got %0d required 1", wr_q.size() - wb); end
        else begin
            n_vec++;
            if (wr_q[wb].cyc !== t + 1 || wr_q[wb].addr !== 5'd7 || wr_q[wb].data !== v) begin
                n_bad++; $display("FAIL full_store_write: got +%0d @%0d %h required +1 @7 %h", wr_q[wb].cyc - t, wr_q[wb].addr, wr_q[wb].data, v);
            end
        end
        model[7] = v;
        rb = resp_q.size();
        drive(0, 1'b0, 5'd7, 64'd0, 8'd0, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || resp_q[rb].data !== v) begin n_bad++; $display("FAIL full_store_readback: idx=%0d required %h", idx, v); end
    endtask

    task automatic test_partial_store;
        int t, idx, rb, wb;
        logic [63:0] e;
        preload(5'd0, 64'd51);
        e = exp_merge(model[0], 64'hAB00, 8'h02);
        rb = resp_q.size(); wb = wr_q.size();
        drive(0, 1'b1, 5'd0, 64'hAB00, 8'h02, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || resp_q[rb].cyc !== t + 3) begin n_bad++; $display("FAIL partial_resp: idx=%0d required pulse at +3", idx); end
        n_vec++;
        if (wr_q.size() - wb !== 1) begin n_bad++; $display("FAIL partial_we_count: got %0d required 1", wr_q.size() - wb); end
        else begin
            n_vec++;
            if (wr_q[wb].cyc !== t + 2 || wr_q[wb].data !== e) begin
                n_bad++; $display("FAIL partial_write: got +%0d %h required +2 %h", wr_q[wb].cyc - t, wr_q[wb].data, e);
            end
        end
        model[0] = e;
        rb = resp_q.size();
        drive(0, 1'b0, 5'd0, 64'd0, 8'd0, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || resp_q[rb].data !== 64'hAB33) begin n_bad++; $display("FAIL partial_readback: idx=%0d required %h", idx, 64'hAB33); end
    endtask

    task automatic test_empty_strb;
        int t, idx, rb, wb;
        rb = resp_q.size(); wb = wr_q.size();
        drive(1, 1'b1, 5'd5, {$urandom, $urandom}, 8'h00, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || resp_q[rb].cyc !== t + 2) begin n_bad++; $display("FAIL empty_strb_resp: idx=%0d required pulse at +2", idx); end
        n_vec++;
        if (wr_q.size() !== wb || mem[5] !== model[5]) begin
            n_bad++; $display("FAIL empty_strb_nowrite: writes=%0d mem=%h required 0 writes %h", wr_q.size() - wb, mem[5], model[5]);
        end
    endtask

    task automatic test_reset_mid_merge;
        int t, rb, wb;
        preload(5'd5, 64'd18);
        rb = resp_q.size(); wb = wr_q.size();
        drive(0, 1'b1, 5'd5, {$urandom, $urandom}, 8'h0F, t);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        n_vec++;
        if (mem_We !== 1'b0) begin n_bad++; $display("FAIL rst_merge_we: got %b required 0", mem_We); end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_vec++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_We, mem_endr, mem_din, r0_rdata, r1_rdata} !== 202'd0) begin
            n_bad++; $display("FAIL rst_merge_outputs: outputs not at reset values");
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (resp_q.size() !== rb || wr_q.size() !== wb || mem[5] !== 64'd18) begin
            n_bad++; $display("FAIL rst_merge_effects: resp=%0d writes=%0d mem=%h required 0 0 %h",
                              resp_q.size() - rb, wr_q.size() - wb, mem[5], 64'd18);
        end
    endtask

    task automatic test_out_of_range;
        int t, idx, rb, wb;
        preload(5'd28, 64'hDEAD_BEEF_0000_0001);
        rb = resp_q.size(); wb = wr_q.size();
        drive(0, 1'b0, 5'd28, 64'd0, 8'd0, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || resp_q[rb].data !== 64'd0 || resp_q[rb].cyc !== t + 2) begin
            n_bad++; $display("FAIL oor_load: idx=%0d required rdata 0 at +2", idx);
        end
        rb = resp_q.size();
        drive(1, 1'b1, 5'd30, {$urandom, $urandom}, 8'hFF, t);
        wait_resp(rb, idx);
        n_vec++;
        if (idx < 0 || wr_q.size() !== wb || resp_q[rb].cyc !== t + 2) begin
            n_bad++; $display("FAIL oor_store: idx=%0d writes=%0d required pulse at +2 and no write", idx, wr_q.size() - wb);
        end
    endtask

    task automatic test_random;
        int t, idx, rb, wb, lat, id, sel;
        logic we, inr, full, part;
        logic [4:0]  a;
        logic [7:0]  s;
        logic [63:0] d, erd, nw;
        for (int k = 0; k < 60; k++) begin
            id = $urandom_range(0, 1);
            we = 1'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            d  = {$urandom, $urandom};
            sel = $urandom_range(0, 3);
            s  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            inr  = (int'(a) < DEPTH);
            full = we && inr && (s == 8'hFF);
            part = we && inr && (s != 8'h00) && (s != 8'hFF);
            lat  = part ? 3 : 2;
            erd  = (!we && inr) ? model[a] : 64'd0;
            nw   = exp_merge(model[a], d, s);
            rb = resp_q.size(); wb = wr_q.size();
            drive(id, we, a, d, s, t);
            wait_resp(rb, idx);
            n_vec++;
            if (idx < 0) begin n_bad++; $display("FAIL rnd_resp[%0d]: no rvalid, required one", k); end
            else begin
                n_vec++;
                if (resp_q[idx].id !== id || resp_q[idx].cyc - t !== lat || resp_q[idx].data !== erd) begin
                    n_bad++; $display("FAIL rnd_result[%0d]: got r%0d +%0d %h required r%0d +%0d %h", k,
                                      resp_q[idx].id, resp_q[idx].cyc - t, resp_q[idx].data, id, lat, erd);
                end
            end
            n_vec++;
            if (wr_q.size() - wb !== ((full || part) ? 1 : 0)) begin
                n_bad++; $display("FAIL rnd_we_count[%0d]: got %0d required %0d", k, wr_q.size() - wb, (full || part) ? 1 : 0);
            end else if (full || part) begin
                n_vec++;
                if (wr_q[wb].cyc - t !== (part ? 2 : 1) || wr_q[wb].addr !== a || wr_q[wb].data !== nw) begin
                    n_bad++; $display("FAIL rnd_write[%0d]: got +%0d @%0d %h required +%0d @%0d %h", k, wr_q[wb].cyc - t,
                                      wr_q[wb].addr, wr_q[wb].data, part ? 2 : 1, a, nw);
                end
            end
            if (full || part) model[a] = nw;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (mem[i] !== model[i]) begin n_bad++; $display("FAIL final_mem[%0d]: got %h required %h", i, mem[i], model[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) preload(5'(i), {$urandom, $urandom});
        test_reset;
        test_round_robin;
        test_load;
        test_full_store;
        test_partial_store;
        test_empty_strb;
        test_reset_mid_merge;
        test_out_of_range;
        test_random;
        n_vec++;
        if (both_rdy !== 0 || both_rv !== 0) begin
            n_bad++; $display("FAIL exclusivity: both_ready=%0d both_rvalid=%0d required 0 0", both_rdy, both_rv);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
